chirp_coef_loader: RTL and testbench

//  Sequences the real chirp reference ROM (Q1.15 taps, 1-cycle registered read) into the matched-filter coefficient bank.
//  On start, issues ROM reads over addresses 0..ORDER, forward or time-reversed (h[n]=s[ORDER-n]).

---
 rtl/chirp_coef_loader_pkg.sv | 23 ++
 rtl/chirp_coef_loader_if.sv | 31 +++
 rtl/coef_skid_fifo.sv | 57 +++++
 rtl/chirp_coef_loader.sv | 118 +++++++++++
 tb/tb_chirp_coef_loader.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chirp_coef_loader_pkg.sv
// Shared definitions for the chirp coefficient loader.
//   Q15_MAX / Q15_MIN : Q1.15 full-scale constants
//   DEFAULT_ORDER     : last chirp ROM address (ORDER+1 taps)
//   state_t           : loader FSM encoding
//   credit_ok()       : read-issue credit check (occupancy + in-flight < 2)
package chirp_coef_loader_pkg;

  localparam logic [15:0] Q15_MAX       = 16'h7FFF;
  localparam logic [15:0] Q15_MIN       = 16'h8000;
  localparam int unsigned DEFAULT_ORDER = 60;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic credit_ok(input logic [1:0] occ, input logic inflight);
    return ({1'b0, occ} + {2'b00, inflight}) < 3'd2;
  endfunction

endpackage

// File: rtl/chirp_coef_loader_if.sv
// Control / ROM / coefficient-stream bundle for chirp_coef_loader.
//   master : loader side (drives ROM read and coefficient stream, status)
//   slave  : environment side (control FSM, ROM, matched-filter tap bank)
interface chirp_coef_loader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = 8
);
  logic              start;
  logic              abort;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              coef_valid;
  logic              coef_ready;
  logic [DATA_W-1:0] coef_data;
  logic [IDX_W-1:0]  coef_index;
  logic              coef_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, rom_data, coef_ready,
    output rom_en, rom_addr, coef_valid, coef_data, coef_index, coef_last, busy, done
  );

  modport slave (
    output start, abort, rom_data, coef_ready,
    input  rom_en, rom_addr, coef_valid, coef_data, coef_index, coef_last, busy, done
  );
endinterface

// File: rtl/coef_skid_fifo.sv
// Two-entry FIFO holding {tap, index, last} entries for the loader.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_flush        : synchronous empty (abort)
//   i_push, i_din  : write side
//   i_pop          : read side; head is o_dout while o_valid
//   o_count        : occupancy 0..2, used by the issue-credit check
module coef_skid_fifo #(
  parameter int unsigned W = 25
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_valid,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign w_push = i_push && (r_count != 2'd2);
  assign w_pop  = i_pop && (r_count != 2'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < 2; i++) r_mem[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;
endmodule

// File: rtl/chirp_coef_loader.sv
// Sequences the chirp reference ROM (registered 1-cycle read) into the
// matched-filter coefficient bank as a valid/ready tap stream.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (master)   : start/abort control, ROM read port, coefficient
//                    stream (data/index/last), busy/done status
module chirp_coef_loader
  import chirp_coef_loader_pkg::*;
#(
  parameter int unsigned ORDER   = DEFAULT_ORDER,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned IDX_W   = 8,
  parameter bit          REVERSE = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  chirp_coef_loader_if.master bus
);
  localparam int unsigned FW = DATA_W + IDX_W + 1;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_cnt;
  logic               r_inflight;
  logic [IDX_W-1:0]   r_fl_idx;
  logic               r_fl_last;

  logic               w_issue;
  logic               w_abort;
  logic               w_valid;
  logic               w_bypass;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_last;
  logic [ADDR_W-1:0]  w_addr;
  logic [FW-1:0]      w_fifo_din;
  logic [FW-1:0]      w_fifo_dout;
  logic               w_fifo_valid;
  logic [1:0]         w_occ;

  assign w_abort = bus.abort && (r_state != ST_IDLE);
  assign w_addr  = REVERSE ? (ADDR_W'(ORDER) - ADDR_W'(r_cnt)) : ADDR_W'(r_cnt);

  // A returning ROM word is presented directly when the FIFO is empty and
  // only enters the FIFO if the sink does not take it that cycle; this is
  // what gives coef_valid two cycles after start at full throughput.
  assign w_valid    = w_fifo_valid || r_inflight;
  assign w_bypass   = !w_fifo_valid && r_inflight;
  assign w_accept   = w_valid && bus.coef_ready;
  assign w_push     = r_inflight && !(w_bypass && bus.coef_ready);
  assign w_pop      = w_fifo_valid && bus.coef_ready;
  assign w_last     = w_bypass ? r_fl_last : w_fifo_dout[0];
  assign w_fifo_din = {bus.rom_data, r_fl_idx, r_fl_last};

  coef_skid_fifo #(.W(FW)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (w_abort),
    .i_push  (w_push),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_valid (w_fifo_valid),
    .o_count (w_occ)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (bus.start && !bus.abort) w_next = ST_RUN;
        ST_RUN:   if (w_issue && (r_cnt == IDX_W'(ORDER))) w_next = ST_DRAIN;
        ST_DRAIN: if (w_accept && w_last) w_next = ST_DONE;
        ST_DONE:  w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_issue        = (r_state == ST_RUN) && !bus.abort && credit_ok(w_occ, r_inflight);
    bus.rom_en     = w_issue;
    bus.rom_addr   = w_issue ? w_addr : '0;
    bus.busy       = (r_state != ST_IDLE);
    bus.done       = (r_state == ST_DONE);
    bus.coef_valid = w_valid;
    bus.coef_data  = w_bypass ? bus.rom_data : w_fifo_dout[FW-1 -: DATA_W];
    bus.coef_index = w_bypass ? r_fl_idx : w_fifo_dout[IDX_W:1];
    bus.coef_last  = w_last;
  end

  // Issue counter and the single in-flight tag; rom_data is only ever
  // looked at while r_inflight is set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_inflight <= 1'b0;
      r_fl_idx   <= '0;
      r_fl_last  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (r_state == ST_IDLE) r_cnt <= '0;
      else if (w_issue)       r_cnt <= r_cnt + 1'b1;
      if (w_issue) begin
        r_fl_idx  <= r_cnt;
        r_fl_last <= (r_cnt == IDX_W'(ORDER));
      end
    end
  end
endmodule

// File: tb/tb_chirp_coef_loader.sv
// Self-checking bench for chirp_coef_loader: a reversed-order instance
// (main DUT) and a forward-order instance, each fed by a registered ROM
// model whose output is junk in any cycle not following a read.
module tb_chirp_coef_loader;
  import chirp_coef_loader_pkg::*;

  typedef struct packed {
    logic [7:0]  idx;
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  logic [15:0] rom_tab [61];
  logic [15:0] rq, rq_f, junk;
  logic        rv, rv_f;

  chirp_coef_loader_if #(.ADDR_W(32), .DATA_W(16), .IDX_W(8)) bus ();
  chirp_coef_loader_if #(.ADDR_W(32), .DATA_W(16), .IDX_W(8)) bus_f ();

  chirp_coef_loader #(.ORDER(60), .ADDR_W(32), .DATA_W(16), .IDX_W(8), .REVERSE(1'b1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );
  chirp_coef_loader #(.ORDER(60), .ADDR_W(32), .DATA_W(16), .IDX_W(8), .REVERSE(1'b0)) u_dut_fwd (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chirp ROM contents: known anchor taps, synthetic distinct values elsewhere.
  initial begin
    for (int k = 0; k < 61; k++) rom_tab[k] = 16'(k * 1237 + 4099);
    rom_tab[0]  = Q15_MAX;
    rom_tab[1]  = 16'h7FFB;
    rom_tab[2]  = 16'h7FB0;
    rom_tab[59] = 16'hC1F2;
    rom_tab[60] = 16'h0000;
  end

  always @(posedge clk) begin
    junk <= 16'($urandom);
    rv   <= bus.rom_en;
    rv_f <= bus_f.rom_en;
    if (bus.rom_en)   rq   <= (bus.rom_addr < 32'd61)   ? rom_tab[bus.rom_addr[5:0]]   : 16'hBAD0;
    if (bus_f.rom_en) rq_f <= (bus_f.rom_addr < 32'd61) ? rom_tab[bus_f.rom_addr[5:0]] : 16'hBAD0;
  end
  assign bus.rom_data   = rv   ? rq   : junk;
  assign bus_f.rom_data = rv_f ? rq_f : ~junk;

  task automatic push_expected(input bit rev);
    exp_t e;
    for (int i = 0; i <= 60; i++) begin
      e.idx  = 8'(i);
      e.data = rom_tab[rev ? 60 - i : i];
      e.last = (i == 60);
      sb.push_back(e);
    end
  endtask

  // One clock: drive inputs just after the rising edge, return at the falling edge.
  task automatic step(input logic st, input logic ab, input logic rdy, input logic st_f = 1'b0);
    @(posedge clk);
    #1;
    bus.start      = st;
    bus.abort      = ab;
    bus.coef_ready = rdy;
    bus_f.start    = st_f;
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++;
    if ({bus.rom_en, bus.rom_addr, bus.coef_valid, bus.coef_data, bus.coef_index,
         bus.coef_last, bus.busy, bus.done} !== 60'd0) begin
      bad++;
      $display("FAIL reset_rev got en=%b addr=%0d v=%b d=%h i=%0d l=%b busy=%b done=%b want all 0",
               bus.rom_en, bus.rom_addr, bus.coef_valid, bus.coef_data, bus.coef_index,
               bus.coef_last, bus.busy, bus.done);
    end
    total++;
    if ({bus_f.rom_en, bus_f.coef_valid, bus_f.coef_data, bus_f.coef_index, bus_f.busy, bus_f.done} !== 28'd0) begin
      bad++;
      $display("FAIL reset_fwd got en=%b v=%b d=%h i=%0d busy=%b want all 0",
               bus_f.rom_en, bus_f.coef_valid, bus_f.coef_data, bus_f.coef_index, bus_f.busy);
    end
  endtask

  task automatic test_full_rev();
    exp_t e;
    int first_en = -1, first_v = -1, vcnt = 0, hs = 0, last_hs = -1, dones = 0, done_c = -1;
    push_expected(1'b1);
    step(1'b1, 1'b0, 1'b1);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rev_busy_in_start_cycle got=%b want=0", bus.busy); end
    for (int c = 1; c < 200 && (done_c < 0 || c <= done_c + 1); c++) begin
      step(1'b0, 1'b0, 1'b1);
      if (bus.rom_en && first_en < 0) first_en = c;
      if (bus.coef_valid) begin vcnt++; if (first_v < 0) first_v = c; end
      if (bus.done) begin dones++; done_c = c; end
      if (bus.coef_valid && bus.coef_ready) begin
        hs++; last_hs = c; total++;
        if (sb.size() == 0) begin bad++; $display("FAIL rev_extra_tap got idx=%0d want none", bus.coef_index); end
        else begin
          e = sb.pop_front();
          if ({bus.coef_index, bus.coef_data, bus.coef_last} !== e) begin
            bad++;
            $display("FAIL rev_tap got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                     bus.coef_index, bus.coef_data, bus.coef_last, e.idx, e.data, e.last);
          end
        end
      end
    end
    total++; if (first_en != 1) begin bad++; $display("FAIL rev_first_rom_en got=%0d want=1", first_en); end
    total++; if (first_v != 2) begin bad++; $display("FAIL rev_first_valid got=%0d want=2", first_v); end
    total++; if (vcnt != 61 || last_hs != 62) begin bad++; $display("FAIL rev_valid_run got cnt=%0d last=%0d want cnt=61 last=62", vcnt, last_hs); end
    total++; if (dones != 1 || done_c != 63) begin bad++; $display("FAIL rev_done got n=%0d at=%0d want n=1 at=63", dones, done_c); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL rev_missing_taps got=%0d want=0", sb.size()); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rev_busy_after_done got=%b want=0", bus.busy); end
    sb.delete();
  endtask

  task automatic test_forward();
    exp_t e;
    int vcnt = 0, hs = 0, dones = 0, done_c = -1, first_v = -1;
    push_expected(1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int c = 1; c < 200 && (done_c < 0 || c <= done_c + 1); c++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      if (bus_f.coef_valid) begin vcnt++; if (first_v < 0) first_v = c; end
      if (bus_f.done) begin dones++; done_c = c; end
      if (bus_f.coef_valid && bus_f.coef_ready) begin
        hs++; total++;
        if (sb.size() == 0) begin bad++; $display("FAIL fwd_extra_tap got idx=%0d want none", bus_f.coef_index); end
        else begin
          e = sb.pop_front();
          if ({bus_f.coef_index, bus_f.coef_data, bus_f.coef_last} !== e) begin
            bad++;
            $display("FAIL fwd_tap got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                     bus_f.coef_index, bus_f.coef_data, bus_f.coef_last, e.idx, e.data, e.last);
          end
        end
      end
    end
    total++; if (first_v != 2 || vcnt != 61) begin bad++; $display("FAIL fwd_valid_run got first=%0d cnt=%0d want first=2 cnt=61", first_v, vcnt); end
    total++; if (dones != 1 || hs != 61) begin bad++; $display("FAIL fwd_done got n=%0d hs=%0d want n=1 hs=61", dones, hs); end
    sb.delete();
  endtask

  task automatic test_backpressure();
    exp_t e;
    int hs = 0, dones = 0, done_c = -1, iss = 0, acc = 0;
    bit stall_prev = 1'b0;
    logic [15:0] pd = '0;
    logic [7:0]  pi = '0;
    push_expected(1'b1);
    step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    for (int c = 1; c < 1000 && (done_c < 0 || c <= done_c + 1); c++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      if (bus.rom_en) begin
        total++;
        if (iss - acc >= 2) begin bad++; $display("FAIL bp_credit got outstanding=%0d want <2", iss - acc); end
        iss++;
      end
      if (stall_prev) begin
        total++;
        if (bus.coef_valid !== 1'b1 || bus.coef_data !== pd || bus.coef_index !== pi) begin
          bad++;
          $display("FAIL bp_hold got v=%b d=%h i=%0d want v=1 d=%h i=%0d",
                   bus.coef_valid, bus.coef_data, bus.coef_index, pd, pi);
        end
      end
      stall_prev = bus.coef_valid && !bus.coef_ready;
      pd = bus.coef_data;
      pi = bus.coef_index;
      if (bus.done) begin dones++; done_c = c; end
      if (bus.coef_valid && bus.coef_ready) begin
        hs++; acc++; total++;
        if (sb.size() == 0) begin bad++; $display("FAIL bp_extra_tap got idx=%0d want none", bus.coef_index); end
        else begin
          e = sb.pop_front();
          if ({bus.coef_index, bus.coef_data, bus.coef_last} !== e) begin
            bad++;
            $display("FAIL bp_tap got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                     bus.coef_index, bus.coef_data, bus.coef_last, e.idx, e.data, e.last);
          end
        end
      end
    end
    total++; if (hs != 61 || iss != 61) begin bad++; $display("FAIL bp_count got hs=%0d issues=%0d want 61/61", hs, iss); end
    total++; if (dones != 1) begin bad++; $display("FAIL bp_done got=%0d want=1", dones); end
    sb.delete();
  endtask

  task automatic test_abort();
    exp_t e;
    int hs = 0, quiet = 0, dones = 0, done_c = -1;
    push_expected(1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int c = 1; c < 200 && hs < 10; c++) begin
      step(1'b0, 1'b0, 1'b1);
      if (bus.coef_valid && bus.coef_ready) begin
        hs++; total++;
        e = sb.pop_front();
        if ({bus.coef_index, bus.coef_data, bus.coef_last} !== e) begin
          bad++;
          $display("FAIL abort_pre_tap got idx=%0d data=%h want idx=%0d data=%h",
                   bus.coef_index, bus.coef_data, e.idx, e.data);
        end
      end
    end
    step(1'b0, 1'b1, 1'b0);
    sb.delete();
    step(1'b0, 1'b0, 1'b1);
    total++;
    if ({bus.busy, bus.coef_valid, bus.rom_en} !== 3'b000) begin
      bad++;
      $display("FAIL abort_next_cycle got busy=%b valid=%b rom_en=%b want 0 0 0", bus.busy, bus.coef_valid, bus.rom_en);
    end
    for (int c = 0; c < 80; c++) begin
      step(1'b0, 1'b0, 1'b1);
      quiet += int'(bus.coef_valid) + int'(bus.done) + int'(bus.busy) + int'(bus.rom_en);
    end
    total++; if (quiet != 0) begin bad++; $display("FAIL abort_quiet got activity=%0d want=0", quiet); end
    hs = 0;
    push_expected(1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int c = 1; c < 200 && (done_c < 0 || c <= done_c + 1); c++) begin
      step(1'b0, 1'b0, 1'b1);
      if (bus.done) begin dones++; done_c = c; end
      if (bus.coef_valid && bus.coef_ready) begin
        hs++; total++;
        if (sb.size() == 0) begin bad++; $display("FAIL reload_extra_tap got idx=%0d want none", bus.coef_index); end
        else begin
          e = sb.pop_front();
          if ({bus.coef_index, bus.coef_data, bus.coef_last} !== e) begin
            bad++;
            $display("FAIL reload_tap got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                     bus.coef_index, bus.coef_data, bus.coef_last, e.idx, e.data, e.last);
          end
        end
      end
    end
    total++; if (hs != 61 || dones != 1) begin bad++; $display("FAIL reload_count got hs=%0d done=%0d want 61/1", hs, dones); end
    sb.delete();
  endtask

  task automatic test_start_ignored();
    exp_t e;
    int hs = 0, dones = 0, done_c = -1;
    push_expected(1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int c = 1; c < 200 && (done_c < 0 || c <= done_c + 1); c++) begin
      step(1'(c == 5 || c == 30 || c == 63), 1'b0, 1'b1);
      if (bus.done) begin dones++; done_c = c; end
      if (bus.coef_valid && bus.coef_ready) begin
        hs++; total++;
        if (sb.size() == 0) begin bad++; $display("FAIL busy_start_extra_tap got idx=%0d want none", bus.coef_index); end
        else begin
          e = sb.pop_front();
          if ({bus.coef_index, bus.coef_data, bus.coef_last} !== e) begin
            bad++;
            $display("FAIL busy_start_tap got idx=%0d data=%h want idx=%0d data=%h",
                     bus.coef_index, bus.coef_data, e.idx, e.data);
          end
        end
      end
    end
    total++; if (hs != 61 || dones != 1) begin bad++; $display("FAIL busy_start_count got hs=%0d done=%0d want 61/1", hs, dones); end
    step(1'b0, 1'b0, 1'b1);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_on_done got busy=%b want=0", bus.busy); end
    sb.delete();
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_abort_start got busy=%b want=0", bus.busy); end
    step(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    total++;
    if ({bus.busy, bus.coef_valid} !== 2'b00) begin
      bad++; $display("FAIL run_abort_start got busy=%b valid=%b want 0 0", bus.busy, bus.coef_valid);
    end
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 1'b1);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL run_abort_start_idle got busy=%b want=0", bus.busy); end
  endtask

  task automatic test_reset_midload();
    exp_t e;
    int hs = 0, dones = 0, done_c = -1;
    step(1'b1, 1'b0, 1'b1);
    for (int c = 1; c < 200 && hs < 30; c++) begin
      step(1'b0, 1'b0, 1'b1);
      if (bus.coef_valid && bus.coef_ready) hs++;
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.rom_en, bus.rom_addr, bus.coef_valid, bus.coef_data, bus.coef_index,
         bus.coef_last, bus.busy, bus.done} !== 60'd0) begin
      bad++;
      $display("FAIL async_reset got en=%b addr=%0d v=%b d=%h i=%0d l=%b busy=%b done=%b want all 0",
               bus.rom_en, bus.rom_addr, bus.coef_valid, bus.coef_data, bus.coef_index,
               bus.coef_last, bus.busy, bus.done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    hs = 0;
    push_expected(1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int c = 1; c < 200 && (done_c < 0 || c <= done_c + 1); c++) begin
      step(1'b0, 1'b0, 1'b1);
      if (bus.done) begin dones++; done_c = c; end
      if (bus.coef_valid && bus.coef_ready) begin
        hs++; total++;
        if (sb.size() == 0) begin bad++; $display("FAIL post_reset_extra_tap got idx=%0d want none", bus.coef_index); end
        else begin
          e = sb.pop_front();
          if ({bus.coef_index, bus.coef_data, bus.coef_last} !== e) begin
            bad++;
            $display("FAIL post_reset_tap got idx=%0d data=%h want idx=%0d data=%h",
                     bus.coef_index, bus.coef_data, e.idx, e.data);
          end
        end
      end
    end
    total++; if (hs != 61 || dones != 1) begin bad++; $display("FAIL post_reset_count got hs=%0d done=%0d want 61/1", hs, dones); end
    sb.delete();
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.coef_ready   = 1'b0;
    bus_f.start      = 1'b0;
    bus_f.abort      = 1'b0;
    bus_f.coef_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    test_full_rev();
    test_forward();
    test_backpressure();
    test_abort();
    test_start_ignored();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
